// File: rtl/i2s_if.sv
// i2s_if: sample-source and serial-output bundle of the I2S transmitter.
//   master modport : used by the transmitter (drives the I2S lines and FIFO status)
//   slave modport  : used by the sample source (drives enable, write_enable, wdata)
// Signals:
//   enable             request for serial output
//   write_enable/wdata FIFO push strobe and sample (left, right, left, ...)
//   bclk/lrclk/sdata   I2S bit clock, word select and serial data
//   input_ready        FIFO not full
//   fifo_count         FIFO occupancy
//   buffer_full_error  sticky overflow flag
//   buffer_empty_error sticky underrun flag
interface i2s_if #(
    parameter int unsigned I2S_DATA_BIT_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH         = 8
);
    logic                                  enable;
    logic                                  write_enable;
    logic [I2S_DATA_BIT_WIDTH-1:0]         wdata;
    logic                                  bclk;
    logic                                  lrclk;
    logic                                  sdata;
    logic                                  input_ready;
    logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count;
    logic                                  buffer_full_error;
    logic                                  buffer_empty_error;

    modport master (
        input  enable, write_enable, wdata,
        output bclk, lrclk, sdata, input_ready, fifo_count,
               buffer_full_error, buffer_empty_error
    );

    modport slave (
        output enable, write_enable, wdata,
        input  bclk, lrclk, sdata, input_ready, fifo_count,
               buffer_full_error, buffer_empty_error
    );
endinterface

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: I2S master transmitter with a sample FIFO.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-low reset
//   bus  i2s_if.master: enable/write_enable/wdata in; bclk/lrclk/sdata,
//        input_ready, fifo_count and sticky error flags out
// Frames are 64 bclk periods: left slot bit_cnt 0..31 (lrclk=0), right slot
// 32..63 (lrclk=1). Each slot carries one W-bit sample MSB first, starting one
// bclk after the lrclk edge, zero padded.
module i2s_transmitter #(
    parameter int unsigned I2S_DATA_BIT_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH         = 8,
    parameter int unsigned BCLK_DIV           = 4
) (
    input  logic clk,
    input  logic rst,
    i2s_if.master bus
);
    localparam int unsigned W  = I2S_DATA_BIT_WIDTH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DW = $clog2(BCLK_DIV);

    typedef enum logic {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            bclk_q, bclk_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic            lrclk_q, lrclk_d;
    logic            sdata_q, sdata_d;
    logic [W-1:0]    shreg_q, shreg_d;

    logic [W-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_err_q, full_err_d;
    logic            empty_err_q, empty_err_d;

    logic            fifo_full, fifo_empty;
    logic [W-1:0]    head;
    logic            slot_fall;   // bclk fall leaving p=0: sample load point
    logic            push, pop;
    logic [W-1:0]    sample;
    logic [4:0]      p_next;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign head       = mem[rd_ptr_q];

    // FSM, bclk divider, bit counter and shifter.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        shreg_d   = shreg_q;
        slot_fall = 1'b0;
        sample    = '0;
        p_next    = '0;

        unique case (state_q)
            StIdle: begin
                div_d     = '0;
                bclk_d    = 1'b0;
                bit_cnt_d = '0;
                lrclk_d   = 1'b0;
                sdata_d   = 1'b0;
                if (bus.enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (div_q == DW'(BCLK_DIV - 1)) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    if (bclk_q) begin
                        // Falling edge: everything serial moves here.
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        lrclk_d   = bit_cnt_d[5];
                        p_next    = bit_cnt_d[4:0];
                        if (bit_cnt_q[4:0] == 5'd0) begin
                            // Underrun sends a silent slot.
                            slot_fall = 1'b1;
                            sample    = fifo_empty ? '0 : head;
                            sdata_d   = sample[W-1];
                            shreg_d   = {sample[W-2:0], 1'b0};
                        end else begin
                            sdata_d = ((p_next != 5'd0) && (p_next <= 5'(W))) ?
                                      shreg_q[W-1] : 1'b0;
                            shreg_d = {shreg_q[W-2:0], 1'b0};
                        end
                        // Stop only on a frame boundary so L/R pairing survives.
                        if ((bit_cnt_q == 6'd63) && !bus.enable) begin
                            state_d = StIdle;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO bookkeeping and sticky errors.
    always_comb begin
        pop         = slot_fall && !fifo_empty;
        push        = bus.write_enable && (!fifo_full || pop);
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        full_err_d  = full_err_q | (bus.write_enable && fifo_full && !pop);
        empty_err_d = empty_err_q | (slot_fall && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bclk_q      <= 1'b0;
            bit_cnt_q   <= '0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            shreg_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_err_q  <= 1'b0;
            empty_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            bit_cnt_q   <= bit_cnt_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            shreg_q     <= shreg_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_err_q  <= full_err_d;
            empty_err_q <= empty_err_d;
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && rst) begin
            mem[wr_ptr_q] <= bus.wdata;
        end
    end

    // Outputs are forced to their reset values while rst is held low.
    assign bus.bclk               = bclk_q & rst;
    assign bus.lrclk              = lrclk_q & rst;
    assign bus.sdata              = sdata_q & rst;
    assign bus.fifo_count         = rst ? count_q : '0;
    assign bus.input_ready        = ~fifo_full | ~rst;
    assign bus.buffer_full_error  = full_err_q & rst;
    assign bus.buffer_empty_error = empty_err_q & rst;
endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 The block SHALL have parameter I2S_DATA_BIT_WIDTH, default 24, meaning sample width W, legal range 8..31.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning sample FIFO entries, power of 2, minimum 2.
REQ-003 The block SHALL have parameter BCLK_DIV, default 4, meaning clk cycles per bclk half-period, minimum 2.
REQ-004 The block SHALL have port clk, input, 1 bit, system clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit, request for serial output.
REQ-007 The block SHALL have port write_enable, input, 1 bit, FIFO push strobe.
REQ-008 The block SHALL have port wdata, input, W bits, sample to push; samples alternate left, right.
REQ-009 The block SHALL have ports bclk, lrclk and sdata, each output, 1 bit, I2S master clock, word select and data.
REQ-010 The block SHALL have port input_ready, output, 1 bit, high when the FIFO is not full.
REQ-011 The block SHALL have port fifo_count, output, clog2(FIFO_DEPTH+1) bits, current FIFO occupancy.
REQ-012 The block SHALL have ports buffer_full_error and buffer_empty_error, each output, 1 bit, sticky overflow and underrun flags.

Function
REQ-013 FIFO push SHALL occur when write_enable=1 and (fifo not full, or a pop occurs in the same cycle); occupancy is unchanged on a simultaneous push and pop.
REQ-014 Write_enable=1 with the FIFO full and no same-cycle pop SHALL drop wdata and set buffer_full_error.
REQ-015 FSM states SHALL be IDLE and RUN; IDLE holds bclk=0, lrclk=0, sdata=0, the divider at 0 and bit_cnt at 0.
REQ-016 IDLE to RUN SHALL occur on the first cycle enable=1; the frame starts at bit_cnt=0.
REQ-017 In RUN, bclk SHALL toggle every BCLK_DIV clk cycles, with the first rise BCLK_DIV cycles after entering RUN.
REQ-018 bit_cnt (6 bits, 0..63) SHALL advance on each bclk falling edge, wrapping 63 to 0.
REQ-019 lrclk SHALL equal bit_cnt[5], updated together with bit_cnt, giving 0 = left slot (bits 0..31) and 1 = right slot (bits 32..63).
REQ-020 With p = bit_cnt mod 32: at p=0 the shift register SHALL load the FIFO head and pop it.
REQ-021 With the FIFO empty at p=0, the shift register SHALL load 0 and buffer_empty_error SHALL be set.
REQ-022 sdata SHALL be 0 at p=0, SHALL carry sample bit W-p for p=1..W (MSB first, one bclk after the lrclk edge), and SHALL be 0 for p>W.
REQ-023 sdata, lrclk and bit_cnt SHALL change only on the clk cycle where bclk goes 1 to 0.
REQ-024 enable=0 in RUN SHALL complete the current 64-bit frame, then go to IDLE at the falling edge where bit_cnt wraps to 0; no pop occurs at that edge.
REQ-025 enable returning to 1 before the frame completes SHALL keep the block in RUN with no gap.
REQ-026 Pops SHALL occur only in RUN at p=0, one per 32-bit slot, so left/right order is preserved across frames.
REQ-027 Both error flags SHALL clear only by reset.

Reset
REQ-028 While rst=0, every output SHALL be 0 (bclk, lrclk, sdata, fifo_count, both error flags) except input_ready=1.
REQ-029 Reset SHALL empty the FIFO, set the FSM to IDLE, and clear the divider, bit_cnt and shift register.
REQ-030 Reset asserted mid-frame SHALL take effect on the next clk edge, with output lines low in that same cycle.
REQ-031 After reset release, the first frame SHALL begin only per REQ-016.

Verification
REQ-032 Bench SHALL check (W=24, DIV=2): push 0xABCDEF, then 0x123456, then enable=1 -> lrclk low for 32 bclk; sdata bits p=1..24 = 0xABCDEF MSB-first; right slot = 0x123456; p=0 and p=25..31 are 0.
REQ-033 Bench SHALL check: 8 pushes into an empty FIFO, then a 9th push with enable=0 -> fifo_count=8, input_ready=0, buffer_full_error=1, 9th sample never appears on sdata.
REQ-034 Bench SHALL check: enable=1 with an empty FIFO -> sdata all 0 and buffer_empty_error=1 at the first bclk fall; bclk period = 2*DIV clk cycles.
REQ-035 Bench SHALL check: FIFO full, write_enable=1 on the pop cycle at p=0 -> push accepted, fifo_count stays 8, no full error.
REQ-036 Bench SHALL check: enable deasserted at bit_cnt=10 -> bclk continues to frame end (bit 63), then IDLE with all lines 0; re-enable restarts at the left slot.
REQ-037 Bench SHALL check: rst=0 at bit_cnt=40 -> the next cycle has all outputs per REQ-028 and fifo_count=0.
